div: RTL

- Sequential sign-magnitude divider for the MIX DIV instruction (command 4); counterpart of the multiplier.
- Divides the 60-bit magnitude held in rA:rX by a 30-bit divisor magnitude and returns a signed 30-bit quotient, a signed 30-bit remainder and an overflow flag.
- Uses the same start/stop single-cycle pulse handshake as the other arithmetic units in the MIX core.
- Computes one quotient bit per cycle (restoring division).

---
 rtl/mix_pkg.sv | 14 +
 rtl/div_if.sv | 36 +++
 rtl/div_step.sv | 31 +++
 rtl/div.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// -----------------------------------------------------------------------------
// mix_pkg
//   Constants shared by the MIX arithmetic units (mul, div) and the ALU decode.
//   WORD_W   : magnitude width of one MIX word
//   SIGN_BIT : bit index of the sign in a full MIX word (1 = minus)
//   CMD_DIV  : command code of the DIV instruction
// -----------------------------------------------------------------------------
package mix_pkg;

    localparam int WORD_W   = 30;
    localparam int SIGN_BIT = WORD_W;
    localparam int CMD_DIV  = 4;

endpackage

// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if
//   Start/stop pulse handshake and operand/result bus of the MIX divider.
//   start    : single-cycle request, operands valid in the same cycle
//   a        : rA, bit W = sign, low W bits = high half of dividend magnitude
//   x        : rX magnitude, low half of the dividend
//   v        : divisor, bit W = sign, low W bits = magnitude
//   stop     : single-cycle completion pulse
//   quot/rem : sign-magnitude quotient and remainder
//   overflow : quotient does not fit, or divide by zero
//   master drives the request side, slave (the divider) drives the results.
// -----------------------------------------------------------------------------
interface div_if #(
    parameter int W = mix_pkg::WORD_W
);

    logic         start;
    logic [W:0]   a;
    logic [W-1:0] x;
    logic [W:0]   v;
    logic         stop;
    logic [W:0]   quot;
    logic [W:0]   rem;
    logic         overflow;

    modport master (
        output start, a, x, v,
        input  stop, quot, rem, overflow
    );

    modport slave (
        input  start, a, x, v,
        output stop, quot, rem, overflow
    );

endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division step.
//   i_r     : partial remainder (W bits, always below the divisor on entry)
//   i_q_msb : dividend bit shifted into the remainder this step
//   i_d     : divisor magnitude
//   o_r     : new partial remainder
//   o_qbit  : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int W = 30
) (
    input  logic [W-1:0] i_r,
    input  logic         i_q_msb,
    input  logic [W-1:0] i_d,
    output logic [W:0]   o_r,
    output logic         o_qbit
);

    logic [W:0] w_shift;
    logic [W:0] w_diff;

    // Shifted remainder is below 2*D, so W+1 bits always hold it.
    always_comb begin
        w_shift = {i_r, i_q_msb};
        w_diff  = w_shift - {1'b0, i_d};
        o_qbit  = (w_shift >= {1'b0, i_d});
        o_r     = o_qbit ? w_diff : w_shift;
    end

endmodule

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div
//   Sequential sign-magnitude divider for MIX DIV. Divides the 2W-bit magnitude
//   rA:rX by a W-bit divisor magnitude, one quotient bit per cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : div_if.slave (start/a/x/v in, stop/quot/rem/overflow out)
//   Latency: stop after edge 2 (overflow) or edge W+2 (normal), counting the
//   start-sampling edge as edge 1. A start while busy is dropped.
// -----------------------------------------------------------------------------
module div
    import mix_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic clk,
    input  logic rst_n,
    div_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN} state_t;

    localparam int               CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(W - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    // Datapath operands: loaded on start, never reset.
    logic [W:0]   r_racc;
    logic [W-1:0] r_q;
    logic [W-1:0] r_d;
    logic         r_sa;
    logic         r_sv;

    logic         r_stop;
    logic         r_ovf;
    logic [W:0]   r_quot;
    logic [W:0]   r_rem;

    logic [W:0]   w_r_step;
    logic         w_qbit;
    logic         w_load;
    logic         w_ovf_hit;
    logic         w_run_done;
    logic         w_stop_nxt;
    logic         w_ovf_nxt;
    logic [W:0]   w_quot_nxt;
    logic [W:0]   w_rem_nxt;

    div_step #(.W(W)) u_step (
        .i_r     (r_racc[W-1:0]),
        .i_q_msb (r_q[W-1]),
        .i_d     (r_d),
        .o_r     (w_r_step),
        .o_qbit  (w_qbit)
    );

    // High dividend half >= divisor means the quotient needs more than W bits;
    // this also catches a zero divisor.
    assign w_ovf_hit  = (r_state == S_CHECK) && (r_racc >= {1'b0, r_d});
    assign w_run_done = (r_state == S_RUN) && (r_cnt == LAST);
    assign w_load     = (r_state == S_IDLE) && bus.start;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_stop  <= 1'b0;
            r_ovf   <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stop  <= w_stop_nxt;
            r_ovf   <= w_ovf_nxt;
            r_quot  <= w_quot_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_cnt_nxt   = '0;
                w_state_nxt = w_ovf_hit ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_run_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: results only move on a completion
    always_comb begin
        w_stop_nxt = 1'b0;
        w_ovf_nxt  = r_ovf;
        w_quot_nxt = r_quot;
        w_rem_nxt  = r_rem;
        if (w_ovf_hit) begin
            w_stop_nxt = 1'b1;
            w_ovf_nxt  = 1'b1;
            w_quot_nxt = '0;
            w_rem_nxt  = '0;
        end else if (w_run_done) begin
            // Signs come straight from the sign bits, so -0 stays -0.
            w_stop_nxt = 1'b1;
            w_ovf_nxt  = 1'b0;
            w_quot_nxt = {r_sa ^ r_sv, r_q[W-2:0], w_qbit};
            w_rem_nxt  = {r_sa, w_r_step[W-1:0]};
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_racc <= {1'b0, bus.a[W-1:0]};
            r_q    <= bus.x;
            r_d    <= bus.v[W-1:0];
            r_sa   <= bus.a[W];
            r_sv   <= bus.v[W];
        end else if (r_state == S_RUN) begin
            r_racc <= w_r_step;
            r_q    <= {r_q[W-2:0], w_qbit};
        end
    end

    assign bus.stop     = r_stop;
    assign bus.overflow = r_ovf;
    assign bus.quot     = r_quot;
    assign bus.rem      = r_rem;

endmodule
